// File: rtl/snoop_initiator_if.sv
// Snoop initiator bundle: local request, snoop bus, peer responses, memory read and completion.
// Ports (master = initiator side):
//   req_*          local miss/upgrade request and handshake
//   bus_req/gnt    snoop bus arbitration
//   snoop_*        one-cycle broadcast
//   resp_*         per-peer response strobes and flags
//   mem_rd_*       memory read request/accept/data-return
//   done_*         completion pulse with fill state and data source
interface snoop_initiator_if #(
  parameter int unsigned NUM_PEERS = 3,
  parameter int unsigned ADDR_W    = 64
);
  localparam int unsigned PidW = $clog2(NUM_PEERS) + 1;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [2:0]           req_curr_state;
  logic [ADDR_W-1:0]    req_addr;
  logic                 bus_req;
  logic                 bus_gnt;
  logic                 snoop_valid;
  logic [1:0]           snoop_type;
  logic [ADDR_W-1:0]    snoop_addr;
  logic [NUM_PEERS-1:0] resp_valid;
  logic [NUM_PEERS-1:0] resp_provide;
  logic [NUM_PEERS-1:0] resp_hit;
  logic                 mem_rd_valid;
  logic                 mem_rd_ready;
  logic                 mem_rd_done;
  logic                 done_valid;
  logic [2:0]           done_state;
  logic                 done_src_peer;
  logic [PidW-1:0]      done_peer_id;
  logic                 done_error;

  modport master (
    input  req_valid, req_write, req_curr_state, req_addr, bus_gnt,
    input  resp_valid, resp_provide, resp_hit, mem_rd_ready, mem_rd_done,
    output req_ready, bus_req, snoop_valid, snoop_type, snoop_addr, mem_rd_valid,
    output done_valid, done_state, done_src_peer, done_peer_id, done_error
  );

  modport slave (
    output req_valid, req_write, req_curr_state, req_addr, bus_gnt,
    output resp_valid, resp_provide, resp_hit, mem_rd_ready, mem_rd_done,
    input  req_ready, bus_req, snoop_valid, snoop_type, snoop_addr, mem_rd_valid,
    input  done_valid, done_state, done_src_peer, done_peer_id, done_error
  );
endinterface

// File: rtl/snoop_initiator.sv
// Requester side of the MOESI snoop bus. Accepts one local miss/upgrade, arbitrates for the
// bus, broadcasts one snoop, gathers one response per peer, reads memory when no peer supplies
// data, then pulses done with the fill state and data source.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; abandons any transaction in flight
//   io   - snoop_initiator_if.master bundle (request, bus, responses, memory, completion)
// Build option: define SNOOP_TIMEOUT_EN to add a COLLECT watchdog of TIMEOUT_CYCLES cycles.
module snoop_initiator #(
  parameter int unsigned NUM_PEERS      = 3,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  snoop_initiator_if.master io
);
  localparam int unsigned PidW = $clog2(NUM_PEERS) + 1;

  localparam logic [1:0] SnpNone    = 2'b00;
  localparam logic [1:0] SnpRead    = 2'b01;
  localparam logic [1:0] SnpWrite   = 2'b10;
  localparam logic [1:0] SnpUpgrade = 2'b11;

  localparam logic [2:0] MoesiM = 3'b001;
  localparam logic [2:0] MoesiO = 3'b010;
  localparam logic [2:0] MoesiE = 3'b100;
  localparam logic [2:0] MoesiS = 3'b101;
  localparam logic [2:0] MoesiI = 3'b000;

  localparam logic [NUM_PEERS-1:0] PeerOne = {{(NUM_PEERS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StArb, StSnoop, StCollect, StMem, StDone} state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [1:0]           type_q;
  logic                 req_ready_q;
  logic                 bus_req_q;
  logic                 snoop_valid_q;
  logic                 mem_rd_valid_q;
  logic                 mem_acc_q;
  logic [NUM_PEERS-1:0] valid_mask_q;
  logic [NUM_PEERS-1:0] provide_mask_q;
  logic [NUM_PEERS-1:0] hit_mask_q;
  logic [2:0]           fill_state_q;
  logic                 done_valid_q;
  logic [2:0]           done_state_q;
  logic                 done_src_peer_q;
  logic [PidW-1:0]      done_peer_id_q;
  logic                 done_error_q;

  logic                 accept;
  logic                 is_upgrade;
  logic [NUM_PEERS-1:0] new_resp;
  logic [NUM_PEERS-1:0] valid_all;
  logic [NUM_PEERS-1:0] provide_all;
  logic [NUM_PEERS-1:0] hit_all;
  logic                 all_in;
  logic                 multi_prov;
  logic [PidW-1:0]      first_id;
  logic                 mem_fire;
  logic                 tmo_hit;

  assign accept     = io.req_valid & req_ready_q;
  assign is_upgrade = io.req_write & ((io.req_curr_state == MoesiS) |
                                      (io.req_curr_state == MoesiO));

  // Only a peer's first response counts; repeats cannot add provide/hit bits.
  assign new_resp    = io.resp_valid & ~valid_mask_q;
  assign valid_all   = valid_mask_q | io.resp_valid;
  assign provide_all = provide_mask_q | (io.resp_provide & new_resp);
  assign hit_all     = hit_mask_q | (io.resp_hit & new_resp);
  assign all_in      = &valid_all;
  // Clearing the lowest set bit leaves something only if two or more providers answered.
  assign multi_prov  = |(provide_all & (provide_all - PeerOne));

  always_comb begin
    logic found;
    found    = 1'b0;
    first_id = '0;
    for (int i = 0; i < int'(NUM_PEERS); i++) begin
      if (provide_all[i] && !found) begin
        found    = 1'b1;
        first_id = PidW'(i);
      end
    end
  end

  // Memory data may return in the same cycle the request is accepted.
  assign mem_fire = io.mem_rd_done & (mem_acc_q | (mem_rd_valid_q & io.mem_rd_ready));

`ifdef SNOOP_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q;
  // Firing on count TIMEOUT_CYCLES-1 lands DONE exactly TIMEOUT_CYCLES after COLLECT entry.
  assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      type_q          <= SnpNone;
      req_ready_q     <= 1'b0;
      bus_req_q       <= 1'b0;
      snoop_valid_q   <= 1'b0;
      mem_rd_valid_q  <= 1'b0;
      mem_acc_q       <= 1'b0;
      valid_mask_q    <= '0;
      provide_mask_q  <= '0;
      hit_mask_q      <= '0;
      fill_state_q    <= MoesiI;
      done_valid_q    <= 1'b0;
      done_state_q    <= MoesiI;
      done_src_peer_q <= 1'b0;
      done_peer_id_q  <= '0;
      done_error_q    <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      tmo_cnt_q       <= '0;
`endif
    end else begin
      snoop_valid_q <= 1'b0;
      done_valid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            addr_q      <= io.req_addr;
            type_q      <= !io.req_write ? SnpRead : (is_upgrade ? SnpUpgrade : SnpWrite);
            req_ready_q <= 1'b0;
            bus_req_q   <= 1'b1;
            state_q     <= StArb;
          end
        end
        StArb: begin
          if (io.bus_gnt) begin
            bus_req_q     <= 1'b0;
            snoop_valid_q <= 1'b1;
            state_q       <= StSnoop;
          end
        end
        StSnoop: begin
          valid_mask_q   <= '0;
          provide_mask_q <= '0;
          hit_mask_q     <= '0;
`ifdef SNOOP_TIMEOUT_EN
          tmo_cnt_q      <= '0;
`endif
          state_q        <= StCollect;
        end
        StCollect: begin
          valid_mask_q   <= valid_all;
          provide_mask_q <= provide_all;
          hit_mask_q     <= hit_all;
`ifdef SNOOP_TIMEOUT_EN
          tmo_cnt_q      <= tmo_cnt_q + 1'b1;
`endif
          if (all_in) begin
            if (type_q == SnpUpgrade) begin
              done_valid_q    <= 1'b1;
              done_state_q    <= MoesiM;
              done_src_peer_q <= 1'b0;
              done_peer_id_q  <= '0;
              done_error_q    <= multi_prov;
              state_q         <= StDone;
            end else if (|provide_all) begin
              done_valid_q    <= 1'b1;
              done_state_q    <= (type_q == SnpRead) ? MoesiS : MoesiM;
              done_src_peer_q <= 1'b1;
              done_peer_id_q  <= first_id;
              done_error_q    <= multi_prov;
              state_q         <= StDone;
            end else begin
              fill_state_q   <= (type_q == SnpWrite) ? MoesiM :
                                (|hit_all ? MoesiS : MoesiE);
              mem_rd_valid_q <= 1'b1;
              mem_acc_q      <= 1'b0;
              state_q        <= StMem;
            end
          end else if (tmo_hit) begin
            done_valid_q    <= 1'b1;
            done_state_q    <= MoesiI;
            done_src_peer_q <= 1'b0;
            done_peer_id_q  <= '0;
            done_error_q    <= 1'b1;
            state_q         <= StDone;
          end
        end
        StMem: begin
          if (mem_rd_valid_q && io.mem_rd_ready) begin
            mem_rd_valid_q <= 1'b0;
            mem_acc_q      <= 1'b1;
          end
          if (mem_fire) begin
            done_valid_q    <= 1'b1;
            done_state_q    <= fill_state_q;
            done_src_peer_q <= 1'b0;
            done_peer_id_q  <= '0;
            done_error_q    <= 1'b0;
            state_q         <= StDone;
          end
        end
        StDone: begin
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io.req_ready     = req_ready_q;
  assign io.bus_req       = bus_req_q;
  assign io.snoop_valid   = snoop_valid_q;
  assign io.snoop_type    = type_q;
  assign io.snoop_addr    = addr_q;
  assign io.mem_rd_valid  = mem_rd_valid_q;
  assign io.done_valid    = done_valid_q;
  assign io.done_state    = done_state_q;
  assign io.done_src_peer = done_src_peer_q;
  assign io.done_peer_id  = done_peer_id_q;
  assign io.done_error    = done_error_q;
endmodule
